// File: rtl/render_sequencer_pkg.sv
// render_sequencer_pkg
//   Shared definitions for the frame-loop controller of the VGA Pong datapath:
//   FSM state encoding, default timing constants, screen geometry and the
//   helper that sizes the pixel-index bus.
//   No ports (package).
package render_sequencer_pkg;

  localparam int SCREEN_W        = 160;
  localparam int SCREEN_H        = 120;
  localparam int DEF_CLEAR_TICKS = SCREEN_W * SCREEN_H;  // one plot per pixel
  localparam int DEF_FRAME_TICKS = 833333;               // 50 MHz / 60 Hz
  localparam int MIN_IDX_W       = 15;                   // enough for a full-screen clear
  localparam int STATE_W         = 4;

  typedef enum logic [STATE_W-1:0] {
    S_MENU       = 4'd0,
    S_MOVE       = 4'd1,
    S_LOAD_CLEAR = 4'd2,
    S_CLEAR      = 4'd3,
    S_LOAD_SPR   = 4'd4,
    S_DRAW_SPR   = 4'd5,
    S_WAIT       = 4'd6,
    S_PAUSE      = 4'd7
  } state_t;

  // pixel_idx must hold both a clear-pass offset and the largest sprite length
  function automatic int idx_width(input int len_w);
    return (len_w > MIN_IDX_W) ? len_w : MIN_IDX_W;
  endfunction

endpackage

// File: rtl/render_sequencer_if.sv
// render_sequencer_if
//   Bundles the keyboard/datapath-facing signals of render_sequencer.
//   master : the sequencer (consumes enter/pause/gameover/sprite_len,
//            drives the control strobes, sprite_sel and pixel_idx)
//   slave  : the surrounding datapath / keyboard decoder
//   Parameters: NUM_SPRITES, SEL_W, LEN_W, IDX_W (pixel_idx width).
interface render_sequencer_if #(
  parameter int NUM_SPRITES = 3,
  parameter int SEL_W       = 2,
  parameter int LEN_W       = 6,
  parameter int IDX_W       = render_sequencer_pkg::idx_width(LEN_W)
) ();

  logic                         enter;
  logic                         pause;
  logic                         gameover;
  logic [NUM_SPRITES*LEN_W-1:0] sprite_len;

  logic                         menu;
  logic                         move;
  logic                         load_clear;
  logic                         clear_screen;
  logic                         load_sprite;
  logic                         draw_sprite;
  logic [SEL_W-1:0]             sprite_sel;
  logic [IDX_W-1:0]             pixel_idx;
  logic                         reset_delta;
  logic                         plot;
  logic                         paused;
  logic                         overrun;

  modport master (
    input  enter, pause, gameover, sprite_len,
    output menu, move, load_clear, clear_screen, load_sprite, draw_sprite,
           sprite_sel, pixel_idx, reset_delta, plot, paused, overrun
  );

  modport slave (
    output enter, pause, gameover, sprite_len,
    input  menu, move, load_clear, clear_screen, load_sprite, draw_sprite,
           sprite_sel, pixel_idx, reset_delta, plot, paused, overrun
  );

endinterface

// File: rtl/render_sequencer_pass_counter.sv
// pass_counter
//   Up-counter with synchronous clear, count enable and a terminal value.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     clr        : force count to 0 (wins over en)
//     en         : increment
//     last       : terminal value; done = (count >= last)
//     count      : current value
//     done       : terminal value reached
//   SATURATE=1 stops incrementing once done, so the count never wraps.
module pass_counter #(
  parameter int W        = 15,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         done
);

  logic [W-1:0] count_reg, count_next;

  assign done  = (count_reg >= last);
  assign count = count_reg;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && !(SATURATE && done)) begin
      count_next = count_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/render_sequencer.sv
// render_sequencer
//   Frame-loop controller: game update, screen clear, NUM_SPRITES draw passes
//   with runtime lengths (zero-length sprites skipped), then waits out a
//   fixed frame period. Supports pause and flags frame overrun.
//   Ports:
//     clk   : system clock
//     reset : synchronous active-high reset
//     bus   : render_sequencer_if.master (enter/pause/gameover/sprite_len in,
//             control strobes, sprite_sel, pixel_idx out)
//   All outputs are Moore, decoded from registered state and counters.
module render_sequencer
  import render_sequencer_pkg::*;
#(
  parameter int NUM_SPRITES = 3,
  parameter int SEL_W       = 2,
  parameter int LEN_W       = 6,
  parameter int CLEAR_TICKS = DEF_CLEAR_TICKS,
  parameter int FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int FRAME_W     = 20
) (
  input logic               clk,
  input logic               reset,
  render_sequencer_if.master bus
);

  localparam int IDX_W = idx_width(LEN_W);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_TICKS - 1);
  localparam logic [IDX_W-1:0]   CLEAR_LAST = IDX_W'(CLEAR_TICKS - 1);
  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_SPRITES - 1);

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [LEN_W-1:0]   len_reg, len_next;    // length sampled in S_LOAD_SPR
  logic               wait_entry_reg, wait_entry_next;

  logic [LEN_W-1:0]   len_arr [NUM_SPRITES];
  logic [LEN_W-1:0]   cur_len;
  logic               last_sel;

  logic [IDX_W-1:0]   pass_count, pass_last;
  logic               pass_done, pass_clr;
  logic [FRAME_W-1:0] frame_count;
  logic               frame_done, frame_clr, frame_en;

  // unpack per-sprite lengths
  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_len
    assign len_arr[gi] = bus.sprite_len[gi*LEN_W +: LEN_W];
  end

  always_comb begin
    cur_len = '0;
    for (int k = 0; k < NUM_SPRITES; k++) begin
      if (sel_reg == SEL_W'(k)) cur_len = len_arr[k];
    end
  end

  assign last_sel = (sel_reg == SEL_LAST);

  // Shared pixel counter for the clear pass and every sprite pass. It sits at
  // 0 in every other state so each pass starts from offset 0. A draw pass is
  // only entered with a nonzero length, so len_reg-1 never underflows here.
  assign pass_clr  = !((state_reg == S_CLEAR) || (state_reg == S_DRAW_SPR));
  assign pass_last = (state_reg == S_CLEAR) ? CLEAR_LAST
                                            : (IDX_W'(len_reg) - IDX_W'(1));

  pass_counter #(.W(IDX_W), .SATURATE(1'b0)) u_pass (
    .clk   (clk),
    .reset (reset),
    .clr   (pass_clr),
    .en    (!pass_clr),
    .last  (pass_last),
    .count (pass_count),
    .done  (pass_done)
  );

  // Frame counter reads 0 during S_MOVE (cleared on the way in), so the
  // S_MOVE-to-S_MOVE period is exactly FRAME_TICKS plus pause time.
  assign frame_clr = (state_reg == S_MENU) || (state_next == S_MOVE);
  assign frame_en  = (state_reg != S_MENU) && (state_reg != S_PAUSE);

  pass_counter #(.W(FRAME_W), .SATURATE(1'b1)) u_frame (
    .clk   (clk),
    .reset (reset),
    .clr   (frame_clr),
    .en    (frame_en),
    .last  (FRAME_LAST),
    .count (frame_count),
    .done  (frame_done)
  );

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    len_next        = len_reg;
    wait_entry_next = 1'b0;
    case (state_reg)
      S_MENU: begin
        if (bus.enter) state_next = S_MOVE;
      end
      S_MOVE: begin
        state_next = bus.gameover ? S_MENU : S_LOAD_CLEAR;
      end
      S_LOAD_CLEAR: begin
        state_next = S_CLEAR;
      end
      S_CLEAR: begin
        if (pass_done) begin
          state_next = S_LOAD_SPR;
          sel_next   = '0;
        end
      end
      S_LOAD_SPR: begin
        len_next = cur_len;
        if (cur_len != '0) begin
          state_next = S_DRAW_SPR;
        end else if (last_sel) begin
          state_next      = S_WAIT;
          sel_next        = '0;
          wait_entry_next = 1'b1;
        end else begin
          sel_next = sel_reg + SEL_W'(1);
        end
      end
      S_DRAW_SPR: begin
        if (pass_done) begin
          if (last_sel) begin
            state_next      = S_WAIT;
            sel_next        = '0;
            wait_entry_next = 1'b1;
          end else begin
            state_next = S_LOAD_SPR;
            sel_next   = sel_reg + SEL_W'(1);
          end
        end
      end
      S_WAIT: begin
        // pause beats expiry; the saturated counter expires after unpause
        if (bus.pause)       state_next = S_PAUSE;
        else if (frame_done) state_next = S_MOVE;
      end
      S_PAUSE: begin
        if (bus.pause) state_next = S_WAIT;
      end
      default: state_next = S_MENU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_MENU;
      sel_reg        <= '0;
      len_reg        <= '0;
      wait_entry_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      len_reg        <= len_next;
      wait_entry_reg <= wait_entry_next;
    end
  end

  assign bus.menu         = (state_reg == S_MENU);
  assign bus.move         = (state_reg == S_MOVE);
  assign bus.load_clear   = (state_reg == S_LOAD_CLEAR);
  assign bus.clear_screen = (state_reg == S_CLEAR);
  assign bus.load_sprite  = (state_reg == S_LOAD_SPR);
  assign bus.draw_sprite  = (state_reg == S_DRAW_SPR);
  assign bus.sprite_sel   = ((state_reg == S_LOAD_SPR) || (state_reg == S_DRAW_SPR)) ? sel_reg : '0;
  assign bus.pixel_idx    = pass_clr ? '0 : pass_count;
  assign bus.reset_delta  = (state_reg == S_LOAD_CLEAR) || (state_reg == S_LOAD_SPR);
  assign bus.plot         = (state_reg == S_CLEAR) || (state_reg == S_DRAW_SPR);
  assign bus.paused       = (state_reg == S_PAUSE);
  // Only the first S_WAIT cycle after drawing can flag an overrun; re-entry
  // from S_PAUSE with an expired counter is a normal frame end.
  assign bus.overrun      = (state_reg == S_WAIT) && wait_entry_reg && (frame_count >= FRAME_LAST);

endmodule
